// File: rtl/async_fifo_stream_reader_pkg.sv
// Shared types for the async FIFO read-side stream logic.
package async_fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/async_fifo_stream_reader_skid2.sv
// Two-entry output buffer: head register drives the stream, skid register holds the second word.
module stream_skid2
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  ready,
  output logic                  full
);

  occ_e                  occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  take;

  assign take  = valid & ready;
  assign valid = (occ_q != OCC_EMPTY);
  assign data  = head_q;
  assign full  = (occ_q == OCC_TWO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (push) begin
            occ_d  = OCC_ONE;
            head_d = push_data;
          end
        end
        OCC_ONE: begin
          if (push && take) begin
            head_d = push_data;
          end else if (push) begin
            occ_d  = OCC_TWO;
            skid_d = push_data;
          end else if (take) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (take) begin
            occ_d  = OCC_ONE;
            head_d = skid_q;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/async_fifo_stream_reader.sv
// Read-domain FIFO drainer: pops into a 2-entry buffer and presents a registered valid/ready stream.
module async_fifo_stream_reader
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  flush,
  input  logic                  rd_empty,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  words_out
);

  logic buf_full;
  logic take;

  // Reset term keeps rd_en low while rd_rst_n is held, independent of the clock.
  assign rd_en = rd_rst_n & ~rd_empty & ~flush & ~buf_full;
  assign take  = m_valid & m_ready;

  stream_skid2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (rd_clk),
    .rst_n     (rd_rst_n),
    .flush     (flush),
    .push      (rd_en),
    .push_data (rd_data),
    .valid     (m_valid),
    .data      (m_data),
    .ready     (m_ready),
    .full      (buf_full)
  );

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      words_out <= '0;
    end else if (take && (words_out != '1)) begin
      words_out <= words_out + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_async_fifo_stream_reader.sv
// Directed and randomized-ready bench for async_fifo_stream_reader with a show-ahead FIFO model.
module tb_async_fifo_stream_reader;

  logic        rd_clk = 1'b0;
  logic        rd_rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        m_ready = 1'b0;
  logic        fifo_clr = 1'b0;
  logic        rd_empty;
  logic [7:0]  rd_data;
  logic        rd_en, m_valid;
  logic [7:0]  m_data;
  logic [15:0] words_out;
  logic        rd_en4, m_valid4;
  logic [7:0]  m_data4;
  logic [3:0]  words_out4;

  logic [7:0]  mem [0:1023];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 rd_clk = ~rd_clk;

  assign rd_empty = (rd_ptr == wr_ptr);
  assign rd_data  = mem[rd_ptr[9:0]];

  always @(posedge rd_clk) begin
    if (fifo_clr) rd_ptr <= wr_ptr;
    else if (rd_en) rd_ptr <= rd_ptr + 1;
  end

  async_fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .flush(flush), .rd_empty(rd_empty),
    .rd_data(rd_data), .rd_en(rd_en), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .words_out(words_out)
  );

  async_fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .flush(flush), .rd_empty(rd_empty),
    .rd_data(rd_data), .rd_en(rd_en4), .m_valid(m_valid4), .m_data(m_data4),
    .m_ready(m_ready), .words_out(words_out4)
  );

  task automatic push_word(input logic [7:0] w);
    mem[wr_ptr[9:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    rd_rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0; fifo_clr = 1'b1;
    @(negedge rd_clk); @(negedge rd_clk);
    fifo_clr = 1'b0; rd_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge rd_clk);
    rd_rst_n = 1'b0;
    push_word(8'h5A);
    #1;
    n_total++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %0b want 0", m_valid); else n_pass++;
    n_total++; if (m_data !== 8'h00) $display("FAIL reset_m_data got %h want 00", m_data); else n_pass++;
    n_total++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en got %0b want 0", rd_en); else n_pass++;
    n_total++; if (words_out !== 16'd0) $display("FAIL reset_words_out got %0d want 0", words_out); else n_pass++;
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    #1;
    n_total++; if (rd_en !== 1'b1) $display("FAIL reset_release_rd_en got %0b want 1", rd_en); else n_pass++;
    do_reset();
  endtask

  task automatic test_basic();
    logic [7:0] exp [3];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    do_reset();
    m_ready = 1'b1;
    @(negedge rd_clk);
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    #1;
    n_total++; if (rd_en !== 1'b1) $display("FAIL basic_first_rd_en got %0b want 1", rd_en); else n_pass++;
    n_total++; if (m_valid !== 1'b0) $display("FAIL basic_pre_valid got %0b want 0", m_valid); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge rd_clk); #1;
      n_total++; if (m_valid !== 1'b1 || m_data !== exp[i])
        $display("FAIL basic_beat%0d got v=%0b d=%h want v=1 d=%h", i, m_valid, m_data, exp[i]); else n_pass++;
    end
    @(negedge rd_clk); #1;
    n_total++; if (m_valid !== 1'b0) $display("FAIL basic_drained_valid got %0b want 0", m_valid); else n_pass++;
    n_total++; if (words_out !== 16'd3) $display("FAIL basic_words_out got %0d want 3", words_out); else n_pass++;
  endtask

  task automatic test_stall();
    logic [7:0] exp [4];
    int pops, got;
    exp[0] = 8'hA1; exp[1] = 8'hA2; exp[2] = 8'hA3; exp[3] = 8'hA4;
    do_reset();
    @(negedge rd_clk);
    for (int i = 0; i < 4; i++) push_word(exp[i]);
    pops = 0;
    repeat (5) begin
      #1; if (rd_en) pops++;
      @(negedge rd_clk);
    end
    #1;
    n_total++; if (pops !== 2) $display("FAIL stall_pops got %0d want 2", pops); else n_pass++;
    n_total++; if (m_valid !== 1'b1 || m_data !== 8'hA1)
      $display("FAIL stall_hold got v=%0b d=%h want v=1 d=a1", m_valid, m_data); else n_pass++;
    n_total++; if (rd_en !== 1'b0) $display("FAIL stall_rd_en got %0b want 0", rd_en); else n_pass++;
    m_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (m_valid) begin
        n_total++; if (m_data !== exp[got])
          $display("FAIL stall_order%0d got %h want %h", got, m_data, exp[got]); else n_pass++;
        got++;
      end
      @(negedge rd_clk); #1;
    end
    n_total++; if (got !== 4) $display("FAIL stall_count got %0d want 4", got); else n_pass++;
    n_total++; if (words_out !== 16'd4) $display("FAIL stall_words_out got %0d want 4", words_out); else n_pass++;
  endtask

  task automatic test_random_ready();
    int pushed, got, bad_rd;
    logic [7:0] w;
    do_reset();
    pushed = 0; got = 0; bad_rd = 0;
    for (int c = 0; c < 600 && got < 40; c++) begin
      @(negedge rd_clk);
      if (pushed < 40 && $urandom_range(0, 2) != 0) begin
        w = 8'(pushed * 7 + 3);
        push_word(w);
        pushed++;
      end
      m_ready = 1'($urandom_range(0, 1));
      #1;
      if (rd_en && rd_empty) bad_rd++;
      if (m_valid && m_ready) begin
        w = 8'(got * 7 + 3);
        n_total++; if (m_data !== w) $display("FAIL rand_beat%0d got %h want %h", got, m_data, w); else n_pass++;
        got++;
      end
    end
    n_total++; if (got !== 40) $display("FAIL rand_count got %0d want 40", got); else n_pass++;
    n_total++; if (bad_rd !== 0) $display("FAIL rand_rd_en_when_empty got %0d want 0", bad_rd); else n_pass++;
    @(negedge rd_clk); #1;
    n_total++; if (words_out !== 16'd40) $display("FAIL rand_words_out got %0d want 40", words_out); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    m_ready = 1'b1;
    @(negedge rd_clk);
    push_word(8'hC0);
    repeat (3) @(negedge rd_clk);
    #1;
    n_total++; if (words_out !== 16'd1) $display("FAIL flush_pre_words got %0d want 1", words_out); else n_pass++;
    m_ready = 1'b0;
    push_word(8'hB1); push_word(8'hB2); push_word(8'hB3); push_word(8'hB4);
    repeat (3) @(negedge rd_clk);
    #1;
    n_total++; if (m_valid !== 1'b1 || m_data !== 8'hB1 || rd_en !== 1'b0)
      $display("FAIL flush_two got v=%0b d=%h en=%0b want v=1 d=b1 en=0", m_valid, m_data, rd_en); else n_pass++;
    @(negedge rd_clk);
    flush = 1'b1;
    #1;
    n_total++; if (rd_en !== 1'b0) $display("FAIL flush_two_rd_en got %0b want 0", rd_en); else n_pass++;
    @(negedge rd_clk);
    flush = 1'b0;
    #1;
    n_total++; if (m_valid !== 1'b0 || rd_en !== 1'b1)
      $display("FAIL flush_after got v=%0b en=%0b want v=0 en=1", m_valid, rd_en); else n_pass++;
    @(negedge rd_clk); #1;
    n_total++; if (m_valid !== 1'b1 || m_data !== 8'hB3 || rd_en !== 1'b1)
      $display("FAIL flush_resume got v=%0b d=%h en=%0b want v=1 d=b3 en=1", m_valid, m_data, rd_en); else n_pass++;
    flush = 1'b1;
    #1;
    n_total++; if (rd_en !== 1'b0) $display("FAIL flush_one_rd_en got %0b want 0", rd_en); else n_pass++;
    @(negedge rd_clk);
    flush = 1'b0;
    #1;
    n_total++; if (m_valid !== 1'b0) $display("FAIL flush_one_valid got %0b want 0", m_valid); else n_pass++;
    @(negedge rd_clk); #1;
    n_total++; if (m_valid !== 1'b1 || m_data !== 8'hB4)
      $display("FAIL flush_last got v=%0b d=%h want v=1 d=b4", m_valid, m_data); else n_pass++;
    n_total++; if (words_out !== 16'd1) $display("FAIL flush_words_out got %0d want 1", words_out); else n_pass++;
  endtask

  task automatic test_saturate();
    do_reset();
    m_ready = 1'b1;
    @(negedge rd_clk);
    for (int i = 0; i < 20; i++) push_word(8'(i));
    repeat (26) @(negedge rd_clk);
    #1;
    n_total++; if (words_out4 !== 4'd15) $display("FAIL sat_words_out4 got %0d want 15", words_out4); else n_pass++;
    n_total++; if (words_out !== 16'd20) $display("FAIL sat_words_out16 got %0d want 20", words_out); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    m_ready = 1'b1;
    @(negedge rd_clk);
    push_word(8'hE0);
    repeat (3) @(negedge rd_clk);
    m_ready = 1'b0;
    push_word(8'hE1); push_word(8'hE2); push_word(8'hE3); push_word(8'hE4);
    repeat (3) @(negedge rd_clk);
    #1;
    n_total++; if (m_valid !== 1'b1 || words_out !== 16'd1)
      $display("FAIL arst_pre got v=%0b cnt=%0d want v=1 cnt=1", m_valid, words_out); else n_pass++;
    #2;
    rd_rst_n = 1'b0;
    #1;
    n_total++; if (m_valid !== 1'b0) $display("FAIL arst_m_valid got %0b want 0", m_valid); else n_pass++;
    n_total++; if (rd_en !== 1'b0) $display("FAIL arst_rd_en got %0b want 0", rd_en); else n_pass++;
    n_total++; if (words_out !== 16'd0) $display("FAIL arst_words_out got %0d want 0", words_out); else n_pass++;
    do_reset();
  endtask

  initial begin
    #1 rd_rst_n = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_random_ready();
    test_flush();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
